// File: rtl/matrix_frame_scheduler.sv
// Sequences the enabled transform matrices into the matrix-multiply engine, one valid/ready offer per stage.
// Latency: first offer CORDIC_LAT+1 cycles after the sampled tick; backpressure holds the offer until gpu_ready or TIMEOUT.
module matrix_frame_scheduler #(
  parameter int CORDIC_LAT = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       en,
  input  logic [5:0] cfg_mask,
  input  logic       gpu_ready,
  output logic [3:0] mtrx_sel,
  output logic       mtrx_valid,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(CORDIC_LAT - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [5:0] mask_q;
  logic [7:0] wait_cnt;
  logic [7:0] to_cnt;

  logic [3:0] sel_d;
  logic       valid_d, busy_d, done_d, overrun_d, terr_d;

  // Lowest enabled stage code strictly above cur; 0 when none remain.
  function automatic logic [3:0] next_code(input logic [5:0] m, input logic [3:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (m[i] && (4'(i + 1) > cur) && (r == 4'd0)) r = 4'(i + 1);
    end
    return r;
  endfunction

  logic       start, wait_end, xfer, stall_hit;
  logic [3:0] code_after;

  assign start      = (state == IDLE) && en && frame_tick;
  assign wait_end   = (state == WAIT) && (wait_cnt == WAIT_LAST);
  assign xfer       = mtrx_valid && gpu_ready;
  assign stall_hit  = mtrx_valid && !gpu_ready && (to_cnt == TO_LAST);
  assign code_after = next_code(mask_q, mtrx_sel);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state       <= IDLE;
      mtrx_sel    <= 4'd0;
      mtrx_valid  <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      mtrx_sel    <= sel_d;
      mtrx_valid  <= valid_d;
      frame_busy  <= busy_d;
      frame_done  <= done_d;
      overrun     <= overrun_d;
      timeout_err <= terr_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = WAIT;
      WAIT: begin
        if (!en)           state_nxt = IDLE;
        else if (wait_end) state_nxt = (mask_q != 6'd0) ? ISSUE : DONE;
      end
      ISSUE: begin
        if (!en || stall_hit)                  state_nxt = IDLE;
        else if (xfer && code_after == 4'd0)   state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_d     = mtrx_sel;
    valid_d   = mtrx_valid;
    busy_d    = frame_busy;
    done_d    = 1'b0;
    terr_d    = 1'b0;
    overrun_d = frame_tick && (state != IDLE);
    case (state)
      IDLE: if (start) busy_d = 1'b1;
      WAIT: begin
        if (!en) begin
          {sel_d, valid_d, busy_d} = '0;
        end else if (wait_end) begin
          if (mask_q != 6'd0) begin
            sel_d   = next_code(mask_q, 4'd0);
            valid_d = 1'b1;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!en) begin
          {sel_d, valid_d, busy_d} = '0;
        end else if (stall_hit) begin
          {sel_d, valid_d, busy_d} = '0;
          terr_d = 1'b1;
        end else if (xfer) begin
          if (code_after != 4'd0) begin
            sel_d = code_after;
          end else begin
            {sel_d, valid_d, busy_d} = '0;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Stall counter only runs in ISSUE, so it is already zero on entry.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      mask_q   <= 6'd0;
      wait_cnt <= 8'd0;
      to_cnt   <= 8'd0;
    end else begin
      if (start) begin
        mask_q   <= cfg_mask;
        wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state != ISSUE || xfer)     to_cnt <= 8'd0;
      else if (mtrx_valid && !gpu_ready) to_cnt <= to_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Bench for matrix_frame_scheduler: per-cycle traces compared against a stage-walk reference model.
module tb_matrix_frame_scheduler;
  localparam int L    = 16;
  localparam int TO   = 8;
  localparam int MAXC = 160;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       en = 1'b1;
  logic [5:0] cfg_mask = 6'd0;
  logic       gpu_ready = 1'b0;
  logic [3:0] mtrx_sel;
  logic       mtrx_valid, frame_busy, frame_done, overrun, timeout_err;

  matrix_frame_scheduler #(.CORDIC_LAT(L), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst_n(rst_n), .frame_tick(frame_tick), .en(en), .cfg_mask(cfg_mask),
    .gpu_ready(gpu_ready), .mtrx_sel(mtrx_sel), .mtrx_valid(mtrx_valid),
    .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Trace word: {sel[3:0], valid, busy, done, overrun, timeout_err}
  bit         rdy_a [MAXC];
  bit         tick_a[MAXC];
  bit         en_a  [MAXC];
  bit         rstn_a[MAXC];
  logic [8:0] obs   [MAXC];
  logic [8:0] expv  [MAXC];

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      rdy_a[c] = 1'b1; tick_a[c] = 1'b0; en_a[c] = 1'b1; rstn_a[c] = 1'b1;
    end
    tick_a[0] = 1'b1;
  endtask

  // Walks the enabled stages in ascending order; each holds until a ready cycle or the stall limit.
  task automatic build_model(input logic [5:0] m, input int abort_at, output int len);
    int  t, stall, fend;
    bit  aborted;
    for (int c = 0; c < MAXC; c++) expv[c] = 9'd0;
    for (int c = 1; c <= L; c++) expv[c][3] = 1'b1;
    t = L + 1;
    aborted = 1'b0;
    if (m == 6'd0) begin
      expv[t][2] = 1'b1; fend = t; len = t + 1;
    end else begin
      for (int k = 1; k <= 6; k++) begin
        if (m[k-1] && !aborted) begin
          stall = 0;
          while (!aborted) begin
            expv[t] = {4'(k), 1'b1, 1'b1, 3'b000};
            if (rdy_a[t]) begin t++; break; end
            if (stall + 1 == TO) begin aborted = 1'b1; expv[t+1][0] = 1'b1; end
            else begin stall++; t++; end
          end
        end
      end
      if (aborted) begin fend = t; len = t + 2; end
      else begin expv[t][2] = 1'b1; fend = t; len = t + 1; end
    end
    for (int c = 1; c <= fend; c++) begin
      if (tick_a[c]) begin
        expv[c+1][1] = 1'b1;
        if (c + 2 > len) len = c + 2;
      end
    end
    if (abort_at > 0) begin
      for (int c = abort_at + 1; c < MAXC; c++) expv[c] = 9'd0;
      len = abort_at + 2;
    end
  endtask

  task automatic run_trace(input int len, input logic [5:0] m);
    for (int c = 0; c < len; c++) begin
      @(posedge CLK); #1;
      obs[c] = {mtrx_sel, mtrx_valid, frame_busy, frame_done, overrun, timeout_err};
      frame_tick = tick_a[c];
      gpu_ready  = rdy_a[c];
      en         = en_a[c];
      rst_n      = rstn_a[c];
      cfg_mask   = (c == 0) ? m : 6'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b1; en = 1'b1; cfg_mask = 6'h3F; gpu_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      n_cmp++;
      if ({mtrx_sel, mtrx_valid, frame_busy, frame_done, overrun, timeout_err} !== 9'd0) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %h want 000", c,
                 {mtrx_sel, mtrx_valid, frame_busy, frame_done, overrun, timeout_err});
      end
    end
    rst_n = 1'b1; frame_tick = 1'b0;
  endtask

  task automatic test_nominal();
    int len;
    clear_stim();
    build_model(6'h3F, 0, len);
    run_trace(len, 6'h3F);
    for (int c = 0; c < len; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL nominal cyc %0d: got %h want %h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_backpressure();
    int len;
    clear_stim();
    for (int c = L + 3; c < L + 6; c++) rdy_a[c] = 1'b0;
    build_model(6'h3F, 0, len);
    run_trace(len, 6'h3F);
    for (int c = 0; c < len; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL backpressure cyc %0d: got %h want %h", c, obs[c], expv[c]); end
    end
    n_cmp++;
    if (obs[L+10][2] !== 1'b1) begin n_bad++; $display("FAIL backpressure_done_time: got %b want 1", obs[L+10][2]); end
  endtask

  task automatic test_skip_mask();
    int len;
    logic [5:0] masks[2];
    masks[0] = 6'b100101;
    masks[1] = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      clear_stim();
      for (int c = 0; c < MAXC; c++) rdy_a[c] = 1'($urandom_range(0, 3) != 0);
      build_model(masks[i], 0, len);
      run_trace(len, masks[i]);
      for (int c = 0; c < len; c++) begin
        n_cmp++;
        if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL skip_mask %h cyc %0d: got %h want %h", masks[i], c, obs[c], expv[c]); end
      end
    end
  endtask

  task automatic test_timeout();
    int len;
    for (int i = 0; i < 2; i++) begin
      clear_stim();
      for (int c = 0; c < L + 1 + TO - 1; c++) rdy_a[c] = 1'b0;
      if (i == 0) for (int c = 0; c < MAXC; c++) rdy_a[c] = 1'b0;
      build_model(6'b010011, 0, len);
      run_trace(len, 6'b010011);
      for (int c = 0; c < len; c++) begin
        n_cmp++;
        if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL timeout%0d cyc %0d: got %h want %h", i, c, obs[c], expv[c]); end
      end
    end
  endtask

  task automatic test_overrun();
    int len;
    clear_stim();
    tick_a[5] = 1'b1;
    tick_a[L + 7] = 1'b1;
    build_model(6'h3F, 0, len);
    run_trace(len, 6'h3F);
    for (int c = 0; c < len; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL overrun cyc %0d: got %h want %h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_en_abort();
    int len;
    clear_stim();
    rdy_a[L + 2] = 1'b0;
    en_a[L + 3] = 1'b0;
    build_model(6'h3F, L + 3, len);
    run_trace(len, 6'h3F);
    for (int c = 0; c < len; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL en_abort cyc %0d: got %h want %h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_reset_mid();
    int len;
    logic [5:0] m;
    for (int i = 0; i < 2; i++) begin
      clear_stim();
      m = (i == 0) ? 6'h3F : 6'b011010;
      if (i == 0) rstn_a[L + 4] = 1'b0;
      build_model(m, (i == 0) ? L + 4 : 0, len);
      run_trace(len, m);
      for (int c = 0; c < len; c++) begin
        n_cmp++;
        if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL reset_mid%0d cyc %0d: got %h want %h", i, c, obs[c], expv[c]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic [5:0] m;
    for (int f = 0; f < 16; f++) begin
      clear_stim();
      m = 6'($urandom);
      for (int c = 0; c < MAXC; c++) rdy_a[c] = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) tick_a[$urandom_range(1, L)] = 1'b1;
      build_model(m, 0, len);
      run_trace(len, m);
      for (int c = 0; c < len; c++) begin
        n_cmp++;
        if (obs[c] !== expv[c]) begin n_bad++; $display("FAIL back_to_back f%0d mask %h cyc %0d: got %h want %h", f, m, c, obs[c], expv[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_skip_mask();
    test_timeout();
    test_overrun();
    test_en_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
